// File: rtl/irig_pkg.sv
// rtl/irig_pkg.sv - IRIG-B000 symbol codes, pulse widths, FSM states and frame map
package irig_pkg;

  localparam logic [2:0] SYM_MARK = 3'b111;
  localparam logic [2:0] SYM_ONE  = 3'b011;
  localparam logic [2:0] SYM_ZERO = 3'b001;

  localparam logic [3:0] W_ZERO = 4'd2;
  localparam logic [3:0] W_ONE  = 4'd5;
  localparam logic [3:0] W_MARK = 4'd8;

  localparam int         FRAME_BITS = 100;
  localparam logic [6:0] LAST_BIT   = 7'd99;
  localparam logic [6:0] REQ_BIT    = 7'd90;
  localparam logic [3:0] LAST_MS    = 4'd9;

  // Field start bits; every BCD digit is sent LSB first
  localparam int SEC_U  = 1;
  localparam int SEC_T  = 6;
  localparam int MIN_U  = 10;
  localparam int MIN_T  = 15;
  localparam int HOUR_U = 20;
  localparam int HOUR_T = 25;
  localparam int DAY_U  = 30;
  localparam int DAY_T  = 35;
  localparam int DAY_H  = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP
  } state_t;

  typedef struct packed {
    logic [9:0] day;
    logic [5:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
  } irig_time_t;

  function automatic logic [FRAME_BITS-1:0] mark_mask();
    logic [FRAME_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < FRAME_BITS; i++) m[i] = (i == 0) || (i % 10 == 9);
    return m;
  endfunction

  localparam logic [FRAME_BITS-1:0] MARK_MASK = mark_mask();

  // Number of ms the line stays high for a symbol; 0 for the idle code
  function automatic logic [3:0] sym_width(input logic [2:0] s);
    case (s)
      SYM_MARK: return W_MARK;
      SYM_ONE:  return W_ONE;
      SYM_ZERO: return W_ZERO;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/irig_bit_sel.sv
// rtl/irig_bit_sel.sv - frame-map decode of one bit position to its symbol code
module irig_bit_sel
  import irig_pkg::*;
(
  input  logic [6:0]  bit_idx,
  input  irig_time_t  tod,
  output logic [2:0]  sym
);

  logic [FRAME_BITS-1:0] data;

  always_comb begin
    data = '0;
    data[SEC_U  +: 4] = tod.sec[3:0];
    data[SEC_T  +: 3] = tod.sec[6:4];
    data[MIN_U  +: 4] = tod.min[3:0];
    data[MIN_T  +: 3] = tod.min[6:4];
    data[HOUR_U +: 4] = tod.hour[3:0];
    data[HOUR_T +: 2] = tod.hour[5:4];
    data[DAY_U  +: 4] = tod.day[3:0];
    data[DAY_T  +: 4] = tod.day[7:4];
    data[DAY_H  +: 2] = tod.day[9:8];
    if (MARK_MASK[bit_idx]) sym = SYM_MARK;
    else if (data[bit_idx]) sym = SYM_ONE;
    else                    sym = SYM_ZERO;
  end

endmodule

// File: rtl/irig_gen.sv
// rtl/irig_gen.sv - IRIG-B000 time-code generator: staged BCD time to PWM bit stream
module irig_gen
  import irig_pkg::*;
#(
  parameter int MS_DIV = 100000,
  parameter int DIV_W  = 17
) (
  input  logic        clk,
  input  logic        hrd_rst,
  input  logic        en,
  input  logic        load,
  input  logic [6:0]  sec_bcd,
  input  logic [6:0]  min_bcd,
  input  logic [5:0]  hour_bcd,
  input  logic [9:0]  day_bcd,
  output logic        irig_out,
  output logic [2:0]  sym,
  output logic        sym_valid,
  output logic [6:0]  bit_idx,
  output logic        frame_start,
  output logic        time_req,
  output logic        stale,
  output logic        busy
);

  state_t             state, state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic [3:0]         ms_cnt;
  irig_time_t         staging, shadow, stage_next;
  logic               loaded;
  logic               ms_tick, bit_end, frame_go, new_bit;
  logic [6:0]         idx_next;
  logic [2:0]         sym_next;

  // A coincident load bypasses staging so it still reaches the new frame
  assign stage_next = load ? irig_time_t'({day_bcd, hour_bcd, min_bcd, sec_bcd}) : staging;
  assign ms_tick    = (state != ST_IDLE) && (div_cnt == DIV_W'(MS_DIV - 1));
  assign bit_end    = ms_tick && (ms_cnt == LAST_MS);
  assign busy       = (state != ST_IDLE);
  assign irig_out   = (ms_cnt < sym_width(sym));

  irig_bit_sel u_bit_sel (
    .bit_idx (idx_next),
    .tod     (shadow),
    .sym     (sym_next)
  );

  always_ff @(posedge clk or posedge hrd_rst) begin
    if (hrd_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_go   = 1'b0;
    new_bit    = 1'b0;
    idx_next   = bit_idx;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_next = ST_RUN;
          frame_go   = 1'b1;
          new_bit    = 1'b1;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = en ? ST_RUN : ST_STOP;
        if (bit_end) begin
          if (bit_idx != LAST_BIT) begin
            new_bit  = 1'b1;
            idx_next = bit_idx + 7'd1;
          end else if (en) begin
            frame_go = 1'b1;
            new_bit  = 1'b1;
            idx_next = '0;
          end else begin
            state_next = ST_IDLE;
            idx_next   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge hrd_rst) begin
    if (hrd_rst) begin
      div_cnt     <= '0;
      ms_cnt      <= '0;
      bit_idx     <= '0;
      sym         <= '0;
      sym_valid   <= 1'b0;
      frame_start <= 1'b0;
      time_req    <= 1'b0;
      stale       <= 1'b0;
      staging     <= '0;
      shadow      <= '0;
      loaded      <= 1'b0;
    end else begin
      bit_idx     <= idx_next;
      sym_valid   <= new_bit;
      frame_start <= frame_go;
      time_req    <= new_bit && (idx_next == REQ_BIT);
      staging     <= stage_next;
      if (new_bit)                      sym <= sym_next;
      else if (state_next == ST_IDLE)   sym <= '0;
      if (new_bit || state_next == ST_IDLE) begin
        div_cnt <= '0;
        ms_cnt  <= '0;
      end else if (ms_tick) begin
        div_cnt <= '0;
        ms_cnt  <= ms_cnt + 4'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (frame_go) begin
        shadow <= stage_next;
        stale  <= !(loaded || load);
        loaded <= 1'b0;
      end else if (load) begin
        loaded <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_irig_gen.sv
// tb/tb_irig_gen.sv - self-checking bench for irig_gen with a cycle-counting frame model
module tb_irig_gen;

  localparam int MS_DIV = 4;
  localparam int BIT_CLKS = 10 * MS_DIV;

  logic        clk, hrd_rst, en, load;
  logic [6:0]  sec_bcd, min_bcd;
  logic [5:0]  hour_bcd;
  logic [9:0]  day_bcd;
  logic        irig_out, sym_valid, frame_start, time_req, stale, busy;
  logic [2:0]  sym;
  logic [6:0]  bit_idx;

  int checks = 0;
  int errors = 0;

  irig_gen #(.MS_DIV(MS_DIV), .DIV_W(3)) dut (
    .clk(clk), .hrd_rst(hrd_rst), .en(en), .load(load),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .day_bcd(day_bcd),
    .irig_out(irig_out), .sym(sym), .sym_valid(sym_valid), .bit_idx(bit_idx),
    .frame_start(frame_start), .time_req(time_req), .stale(stale), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame map as a table of BCD digit fields: start bit, length
  localparam int F_START[9] = '{1, 6, 10, 15, 20, 25, 30, 35, 40};
  localparam int F_LEN[9]   = '{4, 3, 4, 3, 4, 2, 4, 4, 2};

  function automatic logic [2:0] model_sym(input int i, input logic [29:0] t);
    int val[9];
    val[0] = int'(t[3:0]);   val[1] = int'(t[6:4]);
    val[2] = int'(t[10:7]);  val[3] = int'(t[13:11]);
    val[4] = int'(t[17:14]); val[5] = int'(t[19:18]);
    val[6] = int'(t[23:20]); val[7] = int'(t[27:24]);
    val[8] = int'(t[29:28]);
    if (i == 0 || i % 10 == 9) return 3'b111;
    for (int k = 0; k < 9; k++)
      if (i >= F_START[k] && i < F_START[k] + F_LEN[k])
        return ((val[k] >> (i - F_START[k])) & 1) != 0 ? 3'b011 : 3'b001;
    return 3'b001;
  endfunction

  function automatic int high_ms(input logic [2:0] s);
    return (s == 3'b111) ? 8 : (s == 3'b011) ? 5 : (s == 3'b001) ? 2 : 0;
  endfunction

  // Behavioural model: counts clocks within a bit, bits within a frame
  bit          m_run = 0, m_sv = 0, m_fs = 0, m_tr = 0, m_loaded = 0, m_stale = 0, m_go;
  int          m_c = 0, m_bit = 0;
  logic [29:0] m_stage = '0, m_shadow = '0, m_nstage;

  always @(posedge clk) begin
    m_sv = 0; m_fs = 0; m_tr = 0; m_go = 0;
    if (hrd_rst) begin
      m_run = 0; m_c = 0; m_bit = 0; m_stage = '0; m_shadow = '0;
      m_loaded = 0; m_stale = 0;
    end else begin
      m_nstage = load ? {day_bcd, hour_bcd, min_bcd, sec_bcd} : m_stage;
      if (!m_run) m_go = en;
      else begin
        m_c++;
        if (m_c == BIT_CLKS) begin
          m_c = 0;
          if (m_bit == 99) begin
            if (en) m_go = 1;
            else begin m_run = 0; m_bit = 0; end
          end else begin
            m_bit++; m_sv = 1; m_tr = (m_bit == 90);
          end
        end
      end
      if (m_go) begin
        m_run = 1; m_c = 0; m_bit = 0; m_fs = 1; m_sv = 1;
        m_shadow = m_nstage; m_stale = !(m_loaded || load); m_loaded = 0;
      end else if (load) m_loaded = 1;
      m_stage = m_nstage;
    end
  end

  logic [2:0] e_sym;
  logic       e_out, e_sv, e_fs, e_tr, e_stale, e_busy;
  logic [6:0] e_idx;

  always @(negedge clk) begin
    if (hrd_rst) begin
      e_sym = 0; e_out = 0; e_sv = 0; e_fs = 0; e_tr = 0; e_stale = 0; e_busy = 0; e_idx = 0;
    end else begin
      e_sym   = m_run ? model_sym(m_bit, m_shadow) : 3'd0;
      e_out   = m_run && (m_c < MS_DIV * high_ms(e_sym));
      e_sv    = m_sv; e_fs = m_fs; e_tr = m_tr; e_stale = m_stale; e_busy = m_run;
      e_idx   = 7'(m_bit);
    end
    checks++;
    if ({irig_out, sym, sym_valid, bit_idx, frame_start, time_req, stale, busy} !==
        {e_out, e_sym, e_sv, e_idx, e_fs, e_tr, e_stale, e_busy}) begin
      errors++;
      $display("FAIL cycle t=%0t got out=%b sym=%b sv=%b idx=%0d fs=%b tr=%b stale=%b busy=%b want out=%b sym=%b sv=%b idx=%0d fs=%b tr=%b stale=%b busy=%b",
               $time, irig_out, sym, sym_valid, bit_idx, frame_start, time_req, stale, busy,
               e_out, e_sym, e_sv, e_idx, e_fs, e_tr, e_stale, e_busy);
    end
  end

  logic [2:0] rec [100];
  always @(negedge clk) if (sym_valid && bit_idx < 100) rec[bit_idx] = sym;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_bit(input int n);
    int t = 0;
    @(negedge clk);
    while (!(sym_valid && bit_idx == 7'(n)) && t < 9000) begin @(negedge clk); t++; end
    if (t >= 9000) begin
      checks++; errors++;
      $display("FAIL wait_bit%0d timeout got %0d cycles want < 9000", n, t);
    end
  endtask

  task automatic measure(output int hi, output int per);
    hi = 0; per = 0;
    do begin
      if (irig_out) hi++;
      per++;
      @(negedge clk);
    end while (!sym_valid && per < 200);
  endtask

  task automatic set_time(input logic [6:0] s, input logic [6:0] m, input logic [5:0] h,
                          input logic [9:0] d);
    sec_bcd = s; min_bcd = m; hour_bcd = h; day_bcd = d;
  endtask

  localparam int T3_IDX[17] = '{1, 2, 3, 4, 6, 7, 8, 10, 11, 12, 13, 20, 21, 22, 23, 40, 41};
  localparam int T3_SYM[17] = '{1, 3, 3, 1, 3, 1, 3, 1, 1, 3, 1, 1, 3, 1, 1, 3, 1};

  int hi, per, n, fs_cnt, fs_pos;

  initial begin
    hrd_rst = 1; en = 0; load = 0;
    set_time(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    hrd_rst = 0;
    @(negedge clk);
    check("rst_out", irig_out, 0);
    check("rst_busy", busy, 0);
    check("rst_sym", sym, 0);
    check("rst_idx", bit_idx, 0);

    // 1: reset in the middle of a frame
    load = 1; @(negedge clk); load = 0; en = 1;
    wait_bit(3);
    check("pre_rst_out", irig_out, 1);
    #2 hrd_rst = 1;
    #1;
    check("async_rst_out", irig_out, 0);
    check("async_rst_sv", sym_valid, 0);
    check("async_rst_busy", busy, 0);
    @(negedge clk); hrd_rst = 0; en = 0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_out", irig_out, 0);

    // 2: pulse widths for 00:00:00 day 000
    set_time(0, 0, 0, 0);
    load = 1; @(negedge clk); load = 0; en = 1;
    wait_bit(0);
    check("a_stale", stale, 0);
    check("a_fs", frame_start, 1);
    measure(hi, per);
    check("w_bit0_hi", hi, 32); check("w_bit0_per", per, 40);
    measure(hi, per);
    check("w_bit1_hi", hi, 8);  check("w_bit1_per", per, 40);
    wait_bit(9);
    measure(hi, per);
    check("w_bit9_hi", hi, 32); check("w_bit9_per", per, 40);

    // 3: content of 12:34:56 day 123 in the next frame
    set_time(7'h56, 7'h34, 6'h12, 10'h123);
    load = 1; @(negedge clk); load = 0;
    wait_bit(0);
    wait_bit(2);
    check("b_stale", stale, 0);
    measure(hi, per);
    check("w_one_hi", hi, 20);
    wait_bit(90);
    check("time_req_90", time_req, 1);
    wait_bit(99);
    for (int k = 0; k < 17; k++)
      check($sformatf("content_bit%0d", T3_IDX[k]), rec[T3_IDX[k]], T3_SYM[k]);

    // 4: bit 99 marker followed directly by bit 0 marker
    hi = 0; fs_cnt = 0; fs_pos = -1;
    for (int k = 0; k < 80; k++) begin
      if (irig_out) hi++;
      if (frame_start) begin fs_cnt++; fs_pos = k; end
      @(negedge clk);
    end
    check("boundary_hi", hi, 64);
    check("boundary_fs_cnt", fs_cnt, 1);
    check("boundary_fs_pos", fs_pos, 40);
    check("c_stale", stale, 1);

    // 5: load on the frame_start edge, then a frame with no load
    wait_bit(99);
    repeat (39) @(posedge clk);
    #1 set_time(7'h58, 7'h59, 6'h23, 10'h365); load = 1;
    @(posedge clk);
    #1 load = 0;
    @(negedge clk);
    check("d_fs", frame_start, 1);
    check("d_stale", stale, 0);
    wait_bit(5);
    check("d_bit1", rec[1], 1);
    check("d_bit4", rec[4], 3);
    wait_bit(0);
    check("e_stale", stale, 1);
    wait_bit(5);
    check("e_bit3", rec[3], 1);
    check("e_bit4", rec[4], 3);

    // 6: drop en at bit 50, frame still completes
    wait_bit(50);
    en = 0; n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check("stop_cycles", n, 2000);
    check("stop_out", irig_out, 0);
    check("stop_idx", bit_idx, 0);

    // en dropped at bit 10 and back at bit 70: next frame follows with no gap
    en = 1;
    wait_bit(10);
    en = 0;
    wait_bit(70);
    check("stop_busy", busy, 1);
    en = 1;
    wait_bit(99);
    measure(hi, per);
    check("resume_per", per, 40);
    check("resume_idx", bit_idx, 0);
    check("resume_fs", frame_start, 1);
    check("resume_busy", busy, 1);
    en = 0;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check("final_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irig_gen.md
Name: irig_gen

Overview:
IRIG-B000 time-code generator, the transmit counterpart of the team's IRIG-B decoder.
- Serialises BCD time of day (seconds, minutes, hours, day-of-year) into the standard 100-bit, 1 s frame of pulse-width-coded bits on irig_out.
- Emits each bit's 3-bit symbol code (same codes the decoder consumes) on sym/sym_valid for loopback and debug.
- Sits between the host time registers and the timing output pin.

Parameters:
MS_DIV, 100000, clk cycles per 1 ms tick (100 MHz clk); minimum 2.
DIV_W, 17, width of the ms prescaler counter; must satisfy 2^DIV_W >= MS_DIV.

Ports:
clk  in  1  system clock
hrd_rst  in  1  reset, asynchronous, active-high
en  in  1  run enable
load  in  1  one-cycle strobe; captures the time inputs into the staging register
sec_bcd  in  7  seconds BCD {tens[2:0], units[3:0]}
min_bcd  in  7  minutes BCD {tens[2:0], units[3:0]}
hour_bcd  in  6  hours BCD {tens[1:0], units[3:0]}
day_bcd  in  10  day-of-year BCD {hundreds[1:0], tens[3:0], units[3:0]}
irig_out  out  1  PWM IRIG-B level
sym  out  3  current bit symbol: 111 marker, 011 one, 001 zero
sym_valid  out  1  one-cycle pulse when a new bit starts
bit_idx  out  7  index 0..99 of the bit being sent
frame_start  out  1  one-cycle pulse at the start of bit 0
time_req  out  1  one-cycle pulse at the start of bit 90; host should load the next second's time
stale  out  1  high if the frame now running used staging data not refreshed by load since the previous frame
busy  out  1  high while not IDLE

Behaviour:
Reset values:
- All outputs 0, bit_idx 0, staging and shadow registers 0, FSM in IDLE.
- hrd_rst mid-frame aborts immediately; irig_out drops in the same cycle.

Staging and shadow registers:
- load writes staging at any time.
- Staging is copied to shadow on the cycle frame_start is issued. If load and that copy coincide, the new load values reach shadow.
- stale is updated on each frame_start: 1 if no load occurred since the previous frame_start, else 0.

Timing:
- Prescaler counts 0..MS_DIV-1; wrap produces ms_tick.
- ms_cnt runs 0..9 within a bit; bit period is 10*MS_DIV clks.
- irig_out is high while ms_cnt < W, with W = 2 (zero), 5 (one), 8 (marker).

FSM states:
- IDLE: irig_out 0, counters held at 0. When en=1, go to RUN next cycle. First bit 0 begins that cycle, with frame_start, sym_valid and irig_out=1 all asserted together.
- RUN: at each bit boundary (ms_tick with ms_cnt=9), advance bit_idx (99 wraps to 0) and register sym, sym_valid and irig_out=1 on the same edge.
- RUN with en=0: go to STOP. en is sampled only to decide whether to continue after bit 99.
- STOP: finish the current frame through the end of bit 99, then go to IDLE. If en returns before bit 99 ends, return to RUN with no gap.

Frame map (BCD fields LSB first):
- Markers at 0, 9, 19, 29, 39, 49, 59, 69, 79, 89, 99.
- Seconds: units 1-4, tens 6-8.
- Minutes: units 10-13, tens 15-17.
- Hours: units 20-23, tens 25-26.
- Day: units 30-33, tens 35-38, hundreds 40-41.
- All other bits are zero.

Input handling:
- No range checking; BCD digits are sent exactly as loaded.

Decomposition:
irig_pkg holds:
- symbol codes SYM_MARK/SYM_ONE/SYM_ZERO;
- pulse widths W_ZERO/W_ONE/W_MARK;
- FSM state encodings;
- the frame-map constants (marker positions, field start bits).

Sub-module irig_bit_sel: combinational (bit_idx, shadow) -> sym.
- Pure decode of the frame map, shared with a future decoder self-check.

Test Plan:
(Bench uses MS_DIV=4, so the bit period is 40 clks.)
1. Reset: assert hrd_rst mid-frame -> irig_out, sym_valid and busy read 0 in the same cycle; after release with en=0 all stay 0.
2. Widths: load 00:00:00 day 000, en=1 -> bit 0 high 32 clks; bit 1 high 8 clks; bit 9 high 32 clks; each bit period exactly 40 clks.
3. Content: load 12:34:56 day 123 -> bits 1-4 = 0,1,1,0; bits 6-8 = 1,0,1; bits 10-13 = 0,0,1,0; bits 20-23 = 0,1,0,0; bits 40-41 = 1,0. Ones high 20 clks; sym matches each bit.
4. Frame boundary: bit 99 marker then bit 0 marker back-to-back (64 high clks across the 80-clk window). frame_start at bit 0 only, time_req at bit 90 only.
5. Load coincident with frame_start -> new time in that frame and stale=0. Next frame with no load -> same time repeated and stale=1.
6. Drop en at bit 50 -> frame completes through bit 99, then busy=0 and irig_out=0. Re-raise en at bit 70 of another frame -> continuous next frame with no gap.
